reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised register file with a per-register scoreboard and an optional write-back bypass. Provides two combinational read ports and one write-back port. Tracks registers with an outstanding (issued, not yet written back) result and raises a stall for the issue stage on RAW and WAW hazards. Sits between decode/issue and write-back in the processor datapath.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W (derived, not overridable)
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and never becomes busy
BYPASS, 1, 1 = same-cycle write-back data is forwarded to read ports and clears hazards combinationally

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
rd_addr1  input  ADDR_W  read port 1 address (source 1 of issuing instruction)
rd_addr2  input  ADDR_W  read port 2 address (source 2)
src1_used  input  1  instruction reads source 1
src2_used  input  1  instruction reads source 2
rd_data1  output  DATA_W  read data 1
rd_data2  output  DATA_W  read data 2
issue_en  input  1  instruction with destination requests issue this cycle
issue_addr  input  ADDR_W  destination register of issuing instruction
stall  output  1  hazard: issue must be held
wr_en  input  1  write-back valid
wr_addr  input  ADDR_W  write-back address
wr_data  input  DATA_W  write-back data
flush  input  1  synchronous clear of all busy bits
busy_vec  output  NUM_REGS  current scoreboard (bit i = register i pending)
pend_cnt  output  ADDR_W+1  number of busy registers

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, busy_vec = 0, pend_cnt = 0. rd_data follows addresses combinationally, i.e. 0 during reset. stall = 0 during reset.
- wz = wr_en & ~(ZERO_REG & wr_addr==0). On posedge, if wz: reg[wr_addr] <= wr_data.
- Reads are combinational: rd_dataN = reg[rd_addrN]. ZERO_REG=1 and rd_addrN==0 -> 0. BYPASS=1 and wz and wr_addr==rd_addrN -> wr_data.
- Effective busy: busy_eff[i] = busy[i] & ~(BYPASS & wz & wr_addr==i).
- Hazards:
  - raw = (src1_used & busy_eff[rd_addr1]) | (src2_used & busy_eff[rd_addr2]).
  - waw = issue_en & busy_eff[issue_addr].
  - stall = raw | waw. stall is purely combinational; it does not depend on flush.
- Issue acceptance: iss = issue_en & ~stall & ~flush & ~(ZERO_REG & issue_addr==0). On posedge, busy[issue_addr] <= 1.
- Write-back clear: on posedge, if wz, busy[wr_addr] <= 0.
  - Exception: iss to the same address in the same cycle. Set wins and busy stays 1.
  - Writing a non-busy register is legal and leaves busy unchanged.
- flush=1: on posedge, all busy <= 0 and pend_cnt <= 0. Overrides issue and clear. The register write still occurs.
- pend_cnt tracks popcount(busy_vec) exactly. It may be maintained as an incremental counter:
  - +1 on an accepted set of a 0 bit.
  - −1 on a clear of a 1 bit.
  - Net 0 when both occur in the same cycle.
  - Never wraps; maximum is NUM_REGS − ZERO_REG.
- Reset asserted mid-operation clears everything immediately, regardless of clk.
- BYPASS=0: same-cycle write-back does not forward data or clear hazards. The stall persists one extra cycle, and data appears on the cycle after the write.

Test Plan:
1. Reset low, then high. Write reg3=16'hA5A5 then read rd_addr1=3 -> rd_data1=16'hA5A5; rd_addr2=0 -> 0. Write reg0=16'hFFFF -> reg0 still reads 0.
2. BYPASS=1: wr_en=1, wr_addr=5, wr_data=16'h1234, rd_addr1=5 in the same cycle -> rd_data1=16'h1234 in that cycle. BYPASS=0 -> old value in that cycle, 16'h1234 on the next cycle.
3. Issue to r2 (pend_cnt 0->1, busy_vec[2]=1). Next cycle src1_used=1, rd_addr1=2 -> stall=1. Write-back r2 -> stall=0 in the write cycle (BYPASS=1) and busy_vec[2]=0 after the edge.
4. Issue r4, then issue_en with issue_addr=4 again -> stall=1 (WAW), and pend_cnt stays 1 until the r4 write-back.
5. Same cycle: write-back r6 (busy) and an accepted issue r6 -> busy_vec[6] remains 1 and pend_cnt unchanged. Issue r1 with flush=1 -> busy_vec=0, pend_cnt=0.
6. Issue r1, r2, r3 (pend_cnt=3), then drop reset asynchronously between edges -> busy_vec=0, pend_cnt=0, all registers read 0 immediately.

Source files
------------

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//   Register file with a per-register scoreboard and an optional write-back
//   bypass.
//
//   Two combinational read ports and one write-back port. A busy bit per
//   register marks an issued result that has not yet been written back. The
//   issue stage is stalled on RAW and WAW hazards against those busy bits.
//
// Parameters
//   DATA_W   : register width in bits
//   ADDR_W   : register address width (NUM_REGS = 2**ADDR_W)
//   ZERO_REG : 1 = register 0 reads as zero, ignores writes, never busy
//   BYPASS   : 1 = same-cycle write-back data is forwarded to the read ports
//              and clears hazards combinationally
//
// Ports
//   clk, reset (async, active-low)
//   rd_addr1/2, src1_used/2 -> rd_data1/2 : read ports and source-use flags
//   issue_en, issue_addr    -> stall      : issue request and hazard stall
//   wr_en, wr_addr, wr_data               : write-back port
//   flush                                 : synchronous clear of all busy bits
//   busy_vec, pend_cnt                    : scoreboard and its population count
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    input  logic                     src1_used,
    input  logic                     src2_used,
    output logic [DATA_W-1:0]        rd_data1,
    output logic [DATA_W-1:0]        rd_data2,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     stall,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     flush,
    output logic [(1<<ADDR_W)-1:0]   busy_vec,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam bit ZR       = (ZERO_REG != 0);
    localparam bit BP       = (BYPASS != 0);

    logic [DATA_W-1:0]   reg_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] busy_eff;
    logic [ADDR_W:0]     pend_cnt_reg;
    logic [ADDR_W:0]     pend_cnt_next;

    logic wz;
    logic iss;
    logic raw;
    logic waw;
    logic cnt_inc;
    logic cnt_dec;

    // A write to the hardwired zero register is dropped entirely.
    assign wz = wr_en & ~(ZR & (wr_addr == '0));

    // Register storage is flip-flop based because every entry must clear on
    // the asynchronous reset.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] q_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q_reg <= '0;
                end else if (wz && (wr_addr == ADDR_W'(gi))) begin
                    q_reg <= wr_data;
                end
            end

            assign reg_q[gi] = q_reg;

            // A register being written back this cycle no longer blocks
            // readers when bypassing is enabled.
            assign busy_eff[gi] = busy_reg[gi] & ~(BP & wz & (wr_addr == ADDR_W'(gi)));
        end
    endgenerate

    // Read ports: storage, then bypass override, then zero-register override.
    always_comb begin
        rd_data1 = reg_q[rd_addr1];
        if (BP && wz && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end
        if (ZR && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end

        rd_data2 = reg_q[rd_addr2];
        if (BP && wz && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end
        if (ZR && (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end
    end

    assign raw   = (src1_used & busy_eff[rd_addr1]) | (src2_used & busy_eff[rd_addr2]);
    assign waw   = issue_en & busy_eff[issue_addr];
    assign stall = raw | waw;

    assign iss = issue_en & ~stall & ~flush & ~(ZR & (issue_addr == '0));

    // Counter deltas mirror actual bit transitions: only a 0->1 set counts up,
    // and a clear is cancelled when an accepted issue re-sets the same bit.
    assign cnt_inc = iss & ~busy_reg[issue_addr];
    assign cnt_dec = wz & busy_reg[wr_addr] & ~(iss & (issue_addr == wr_addr));

    always_comb begin
        busy_next     = busy_reg;
        pend_cnt_next = pend_cnt_reg;
        if (flush) begin
            busy_next     = '0;
            pend_cnt_next = '0;
        end else begin
            if (wz) begin
                busy_next[wr_addr] = 1'b0;
            end
            if (iss) begin
                busy_next[issue_addr] = 1'b1;
            end
            pend_cnt_next = pend_cnt_reg + {{ADDR_W{1'b0}}, cnt_inc}
                                         - {{ADDR_W{1'b0}}, cnt_dec};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_reg     <= '0;
            pend_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            pend_cnt_reg <= pend_cnt_next;
        end
    end

    assign busy_vec = busy_reg;
    assign pend_cnt = pend_cnt_reg;

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
//   Directed and randomized checks of reg_file_sb. Two instances share every
//   input: inst0 with BYPASS=1 and inst1 with BYPASS=0. A behavioural model
//   (arrays of register values and busy flags per instance) predicts every
//   output before each rising edge.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rd_addr1, rd_addr2, issue_addr, wr_addr;
    logic        src1_used, src2_used, issue_en, wr_en, flush;
    logic [15:0] wr_data;

    logic [15:0] d1 [2];
    logic [15:0] d2 [2];
    logic        st [2];
    logic [7:0]  bv [2];
    logic [3:0]  pc [2];

    int tests = 0;
    int fails = 0;

    logic [15:0] m_reg  [2][8];
    bit          m_busy [2][8];

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_bp (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .src1_used(src1_used), .src2_used(src2_used),
        .rd_data1(d1[0]), .rd_data2(d2[0]),
        .issue_en(issue_en), .issue_addr(issue_addr), .stall(st[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flush(flush), .busy_vec(bv[0]), .pend_cnt(pc[0])
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .src1_used(src1_used), .src2_used(src2_used),
        .rd_data1(d1[1]), .rd_data2(d2[1]),
        .issue_en(issue_en), .issue_addr(issue_addr), .stall(st[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flush(flush), .busy_vec(bv[1]), .pend_cnt(pc[1])
    );

    task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s inst%0d: got %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic idle();
        rd_addr1 = 3'd0; rd_addr2 = 3'd0; src1_used = 1'b0; src2_used = 1'b0;
        issue_en = 1'b0; issue_addr = 3'd0;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0; flush = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                m_reg[k][i]  = 16'h0;
                m_busy[k][i] = 1'b0;
            end
    endtask

    // Called one cycle-quarter after the inputs change: compares every output
    // of both instances with the model, then advances the model state.
    task automatic settle();
        #3;
        for (int k = 0; k < 2; k++) begin
            bit          byp = (k == 0);
            bit          wz  = wr_en && (wr_addr != 3'd0);
            bit          beff [8];
            bit          e_st, acc;
            logic [15:0] e1, e2;
            logic [7:0]  e_bv;
            int          e_pc;
            e_bv = 8'h0;
            e_pc = 0;
            for (int i = 0; i < 8; i++) begin
                beff[i] = m_busy[k][i] && !(byp && wz && wr_addr == 3'(i));
                e_bv[i] = m_busy[k][i];
                if (m_busy[k][i]) e_pc++;
            end
            e1 = (rd_addr1 == 0) ? 16'h0 :
                 (byp && wz && wr_addr == rd_addr1) ? wr_data : m_reg[k][rd_addr1];
            e2 = (rd_addr2 == 0) ? 16'h0 :
                 (byp && wz && wr_addr == rd_addr2) ? wr_data : m_reg[k][rd_addr2];
            e_st = (src1_used && beff[rd_addr1]) || (src2_used && beff[rd_addr2])
                || (issue_en && beff[issue_addr]);
            check("rd_data1", k, 32'(d1[k]), 32'(e1));
            check("rd_data2", k, 32'(d2[k]), 32'(e2));
            check("stall",    k, 32'(st[k]), 32'(e_st));
            check("busy_vec", k, 32'(bv[k]), 32'(e_bv));
            check("pend_cnt", k, 32'(pc[k]), 32'(e_pc));

            acc = issue_en && !e_st && !flush && (issue_addr != 3'd0);
            if (wz) m_reg[k][wr_addr] = wr_data;
            if (flush) begin
                for (int i = 0; i < 8; i++) m_busy[k][i] = 1'b0;
            end else begin
                if (wz)  m_busy[k][wr_addr]    = 1'b0;
                if (acc) m_busy[k][issue_addr] = 1'b1;
            end
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        #1;
        $display("[TB] %s: busy=%b/%b pend=%0d/%0d", tag, bv[0], bv[1], pc[0], pc[1]);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        model_reset();
        reset = 1'b0;
        src1_used = 1'b1; rd_addr1 = 3'd5;
        // Outputs during reset.
        settle();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        idle();

        // 1: basic write/read and the zero register.
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5A5;
        settle(); tick("write r3");
        idle(); rd_addr1 = 3'd3; rd_addr2 = 3'd0;
        settle();
        check("t1_rd3", 0, 32'(d1[0]), 32'h0000A5A5);
        check("t1_rd0", 0, 32'(d2[0]), 32'h0);
        tick("read r3");
        idle(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        settle(); tick("write r0");
        idle(); rd_addr2 = 3'd0;
        settle();
        check("t1_r0_zero", 1, 32'(d2[1]), 32'h0);
        tick("read r0");

        // 2: bypass vs. no-bypass forwarding.
        idle(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1111;
        settle(); tick("write r5 old");
        idle(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234; rd_addr1 = 3'd5;
        settle();
        check("t2_bypass", 0, 32'(d1[0]), 32'h1234);
        check("t2_nobypass_old", 1, 32'(d1[1]), 32'h1111);
        tick("write r5 fwd");
        idle(); rd_addr1 = 3'd5;
        settle();
        check("t2_nobypass_new", 1, 32'(d1[1]), 32'h1234);
        tick("read r5");

        // 3: RAW hazard and its release on write-back.
        idle(); issue_en = 1'b1; issue_addr = 3'd2;
        settle(); tick("issue r2");
        idle(); src1_used = 1'b1; rd_addr1 = 3'd2;
        settle();
        check("t3_raw_stall", 0, 32'(st[0]), 32'h1);
        check("t3_pend1", 0, 32'(pc[0]), 32'h1);
        tick("raw r2");
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
        settle();
        check("t3_wb_unstall", 0, 32'(st[0]), 32'h0);
        check("t3_nb_still", 1, 32'(st[1]), 32'h1);
        tick("wb r2");
        idle();
        settle();
        check("t3_busy2_clr", 0, 32'(bv[0][2]), 32'h0);
        tick("idle");

        // 4: WAW hazard holds the count.
        idle(); issue_en = 1'b1; issue_addr = 3'd4;
        settle(); tick("issue r4");
        settle();
        check("t4_waw", 0, 32'(st[0]), 32'h1);
        check("t4_pend", 0, 32'(pc[0]), 32'h1);
        tick("waw r4");
        idle(); wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
        settle(); tick("wb r4");
        idle();
        settle();
        check("t4_pend0", 0, 32'(pc[0]), 32'h0);
        tick("idle");

        // 5: set wins over same-cycle clear; flush overrides issue.
        idle(); issue_en = 1'b1; issue_addr = 3'd6;
        settle(); tick("issue r6");
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
        settle(); tick("wb+issue r6");
        idle();
        settle();
        check("t5_busy6", 0, 32'(bv[0][6]), 32'h1);
        check("t5_pend", 0, 32'(pc[0]), 32'h1);
        tick("idle");
        idle(); issue_en = 1'b1; issue_addr = 3'd1; flush = 1'b1;
        settle(); tick("flush");
        idle();
        settle();
        check("t5_flush_bv", 0, 32'(bv[0]), 32'h0);
        check("t5_flush_pc", 1, 32'(pc[1]), 32'h0);
        tick("idle");

        // 6: asynchronous reset between edges.
        for (int r = 1; r <= 3; r++) begin
            idle(); issue_en = 1'b1; issue_addr = 3'(r);
            settle(); tick("issue");
        end
        idle();
        settle();
        check("t6_pend3", 0, 32'(pc[0]), 32'h3);
        #1;
        reset = 1'b0;
        #1;
        check("t6_rst_bv", 0, 32'(bv[0]), 32'h0);
        check("t6_rst_pc", 0, 32'(pc[0]), 32'h0);
        check("t6_rst_pc_nb", 1, 32'(pc[1]), 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd_addr1 = 3'(a); rd_addr2 = 3'(7 - a);
            #1;
            check("t6_rst_rd1", 0, 32'(d1[0]), 32'h0);
            check("t6_rst_rd2", 1, 32'(d2[1]), 32'h0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rd_addr1   = 3'($urandom_range(0, 7));
            rd_addr2   = 3'($urandom_range(0, 7));
            src1_used  = 1'($urandom);
            src2_used  = 1'($urandom);
            issue_en   = 1'($urandom);
            issue_addr = 3'($urandom_range(0, 7));
            wr_en      = 1'($urandom);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = 16'($urandom);
            flush      = ($urandom_range(0, 15) == 0);
            settle();
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
